// File: rtl/hdmi_pixel_feeder_if.sv
// Pixel request/response bus from the HDMI timing driver together with the
// read port of the show-ahead frame FIFO.
interface hdmi_pixel_feeder_if;
    logic        data_req;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [15:0] video_rgb_565;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;

    modport master (
        output data_req, pixel_xpos, pixel_ypos, fifo_rd_data, fifo_empty,
        input  video_rgb_565, fifo_rd_en
    );

    modport slave (
        input  data_req, pixel_xpos, pixel_ypos, fifo_rd_data, fifo_empty,
        output video_rgb_565, fifo_rd_en
    );
endinterface

// File: rtl/hdmi_pixel_feeder.sv
// Serves RGB565 pixels from a show-ahead FIFO to the HDMI timing driver,
// aligning the FIFO stream to frame boundaries and recovering from underflow.
module hdmi_pixel_feeder #(
    parameter logic [15:0] BG_COLOR        = 16'h0000,
    parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
    input  logic                pixel_clk,
    input  logic                sys_rst_n,
    input  logic                stream_en,
    input  logic                clr_stats,
    input  logic [10:0]         h_disp,
    input  logic [10:0]         v_disp,
    hdmi_pixel_feeder_if.slave  bus,
    output logic                frame_start,
    output logic [15:0]         underflow_cnt,
    output logic                underflow_flag
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_PREFETCH,
        S_ACTIVE
    } state_t;

    state_t      r_state;
    logic [15:0] r_rgb;
    logic        r_frame_start;
    logic [15:0] r_uf_cnt;
    logic        r_uf_flag;

    logic w_first;
    logic w_eof;
    logic w_serve;
    logic w_underflow;

    assign w_first = bus.data_req && (bus.pixel_xpos == 11'd0) && (bus.pixel_ypos == 11'd1);
    assign w_eof   = bus.data_req && (bus.pixel_xpos == (h_disp - 11'd1)) && (bus.pixel_ypos == v_disp);

    // A request is served from the FIFO while streaming, or when it opens the frame
    // we were prefetching for; the FIFO must answer it in the same cycle.
    assign w_serve     = bus.data_req && stream_en &&
                         ((r_state == S_ACTIVE) || ((r_state == S_PREFETCH) && w_first));
    assign w_underflow = w_serve && bus.fifo_empty;

    assign bus.fifo_rd_en    = w_serve && !bus.fifo_empty;
    assign bus.video_rgb_565 = r_rgb;
    assign frame_start       = r_frame_start;
    assign underflow_cnt     = r_uf_cnt;
    assign underflow_flag    = r_uf_flag;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order inside the block.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state       <= S_IDLE;
            r_rgb         <= 16'h0000;
            r_frame_start <= 1'b0;
            r_uf_cnt      <= 16'h0000;
            r_uf_flag     <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_rgb         <= w_serve ? (bus.fifo_empty ? UNDERFLOW_COLOR : bus.fifo_rd_data)
                                     : BG_COLOR;

            if (!stream_en) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_ARM;
                    S_ARM: begin
                        if (w_eof) begin
                            r_frame_start <= 1'b1;
                            r_state       <= S_PREFETCH;
                        end
                    end
                    S_PREFETCH, S_ACTIVE: begin
                        // Underflow on the last pixel resyncs directly: the restart is already due.
                        if (w_serve) begin
                            if (w_eof) begin
                                r_frame_start <= 1'b1;
                                r_state       <= w_underflow ? S_PREFETCH : S_ACTIVE;
                            end else begin
                                r_state <= w_underflow ? S_ARM : S_ACTIVE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (clr_stats) begin
                r_uf_cnt  <= {15'd0, w_underflow};
                r_uf_flag <= w_underflow;
            end else if (w_underflow) begin
                if (r_uf_cnt != 16'hFFFF) begin
                    r_uf_cnt <= r_uf_cnt + 16'd1;
                end
                r_uf_flag <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Self-checking bench for hdmi_pixel_feeder: a directed vector table, frame-level
// scenarios with a ramp-filled FIFO stub, and randomized traffic against a reference model.
module tb_hdmi_pixel_feeder;
    localparam logic [15:0] BG = 16'h0000;
    localparam logic [15:0] UF = 16'hF800;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n;
    logic        stream_en;
    logic        clr_stats;
    logic [10:0] h_disp;
    logic [10:0] v_disp;
    logic        frame_start;
    logic [15:0] underflow_cnt;
    logic        underflow_flag;

    hdmi_pixel_feeder_if bus ();

    hdmi_pixel_feeder dut (
        .pixel_clk      (pixel_clk),
        .sys_rst_n      (sys_rst_n),
        .stream_en      (stream_en),
        .clr_stats      (clr_stats),
        .h_disp         (h_disp),
        .v_disp         (v_disp),
        .bus            (bus),
        .frame_start    (frame_start),
        .underflow_cnt  (underflow_cnt),
        .underflow_flag (underflow_flag)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO stub: prefilled ramp, read pointer restarts on frame_start.
    int unsigned ptr;
    logic        starve;
    logic        pop;
    int          n_pops;
    int          n_fs;

    // Reference model: frame-level bookkeeping of whether we are enabled, locked to
    // the frame sequence, and inside a frame that is being streamed.
    bit          m_seen, m_synced, m_inframe, m_fs, m_flag;
    logic [15:0] m_pix;
    int          m_cnt;

    function automatic bit m_serving();
        bit first;
        first = bus.data_req && (bus.pixel_xpos == 11'd0) && (bus.pixel_ypos == 11'd1);
        return stream_en && m_seen && m_synced && bus.data_req && (m_inframe || first);
    endfunction

    task automatic model_step();
        bit first, eof, srv, uf;
        first = bus.data_req && (bus.pixel_xpos == 11'd0) && (bus.pixel_ypos == 11'd1);
        eof   = bus.data_req && (int'(bus.pixel_xpos) == int'(h_disp) - 1) &&
                (bus.pixel_ypos == v_disp);
        srv   = m_serving();
        uf    = srv && bus.fifo_empty;
        m_pix = srv ? (bus.fifo_empty ? UF : bus.fifo_rd_data) : BG;
        m_fs  = 1'b0;
        if (!stream_en) begin
            m_seen = 0; m_synced = 0; m_inframe = 0;
        end else if (!m_seen) begin
            m_seen = 1;
        end else begin
            m_fs = eof && (!m_synced || srv);
            if (m_fs) begin
                m_synced  = 1;
                m_inframe = srv && !uf;
            end else if (srv) begin
                m_synced  = !uf;
                m_inframe = !uf;
            end
        end
        if (clr_stats) begin
            m_cnt  = uf ? 1 : 0;
            m_flag = uf;
        end else if (uf) begin
            m_cnt  = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            m_flag = 1;
        end
    endtask

    task automatic model_reset();
        m_seen = 0; m_synced = 0; m_inframe = 0; m_fs = 0; m_flag = 0;
        m_pix = BG; m_cnt = 0; ptr = 0;
    endtask

    // One clock cycle; entered and left at posedge+1 with inputs already driven.
    task automatic tick();
        bus.fifo_empty   = starve;
        bus.fifo_rd_data = starve ? 16'($urandom) : 16'(ptr);
        @(negedge pixel_clk);
        check("fifo_rd_en", bus.fifo_rd_en, m_serving() && !bus.fifo_empty);
        pop = bus.fifo_rd_en;
        @(posedge pixel_clk);
        model_step();
        #1;
        check("video_rgb_565", bus.video_rgb_565, m_pix);
        check("frame_start", frame_start, m_fs);
        check("underflow_cnt", underflow_cnt, m_cnt[15:0]);
        check("underflow_flag", underflow_flag, m_flag);
        if (pop) begin ptr++; n_pops++; end
        if (frame_start) begin ptr = 0; n_fs++; end
    endtask

    task automatic do_reset();
        sys_rst_n     = 1'b0;
        bus.data_req  = 1'b0;
        clr_stats     = 1'b0;
        starve        = 1'b0;
        model_reset();
        @(posedge pixel_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic run_frame(input int starve_idx, input int drop_lo, input int drop_hi,
                             input bit ramp, input int exp_pops, input int exp_fs);
        int h, v;
        h = int'(h_disp);
        v = int'(v_disp);
        n_pops = 0;
        n_fs   = 0;
        for (int idx = 0; idx < h * v; idx++) begin
            if ($urandom_range(3) == 0) begin
                bus.data_req = 1'b0;
                starve       = 1'b0;
                tick();
            end
            bus.data_req   = 1'b1;
            bus.pixel_xpos = 11'(idx % h);
            bus.pixel_ypos = 11'(idx / h + 1);
            starve         = (idx == starve_idx);
            stream_en      = !(idx >= drop_lo && idx < drop_hi);
            tick();
            if (ramp) check("ramp_pixel", bus.video_rgb_565, 32'(idx));
        end
        bus.data_req = 1'b0;
        starve       = 1'b0;
        repeat (3) tick();
        check("pops_per_frame", n_pops, exp_pops);
        check("frame_starts_per_frame", n_fs, exp_fs);
    endtask

    typedef struct {
        bit          en, clr, req;
        int          x, y;
        bit          empty;
        logic [15:0] data;
        bit          rd;
        logic [15:0] pix;
        bit          fs;
        int          cnt;
        bit          flag;
    } vec_t;

    function automatic vec_t mk(bit en, bit clr, bit req, int x, int y, bit empty,
                                logic [15:0] data, bit rd, logic [15:0] pix, bit fs,
                                int cnt, bit flag);
        vec_t v;
        v.en = en; v.clr = clr; v.req = req; v.x = x; v.y = y; v.empty = empty;
        v.data = data; v.rd = rd; v.pix = pix; v.fs = fs; v.cnt = cnt; v.flag = flag;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[19];
        int   pos;

        // Directed sequence on a 4x2 frame: en clr req x y empty data | rd pix fs cnt flag
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, BG,       0, 0, 0); // IDLE -> ARM
        tbl[1]  = mk(1, 0, 1, 0, 1, 0, 16'h1111, 0, BG,       0, 0, 0); // ARM ignores first
        tbl[2]  = mk(1, 0, 1, 3, 2, 0, 16'h2222, 0, BG,       1, 0, 0); // EOF in ARM
        tbl[3]  = mk(1, 0, 1, 2, 2, 0, 16'h3333, 0, BG,       0, 0, 0); // PREFETCH waits
        tbl[4]  = mk(1, 0, 1, 0, 1, 0, 16'h0A0A, 1, 16'h0A0A, 0, 0, 0); // first served
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 16'h4444, 0, BG,       0, 0, 0); // no request
        tbl[6]  = mk(1, 0, 1, 1, 1, 0, 16'h1B1B, 1, 16'h1B1B, 0, 0, 0);
        tbl[7]  = mk(1, 0, 1, 2, 1, 1, 16'h5555, 0, UF,       0, 1, 1); // underflow
        tbl[8]  = mk(1, 0, 1, 3, 1, 0, 16'h6666, 0, BG,       0, 1, 1); // rest of frame BG
        tbl[9]  = mk(1, 0, 1, 3, 2, 0, 16'h6767, 0, BG,       1, 1, 1);
        tbl[10] = mk(1, 0, 1, 0, 1, 1, 16'h1234, 0, UF,       0, 2, 1); // underflow on first
        tbl[11] = mk(1, 0, 1, 3, 2, 0, 16'h2345, 0, BG,       1, 2, 1);
        tbl[12] = mk(1, 0, 1, 0, 1, 0, 16'h7777, 1, 16'h7777, 0, 2, 1);
        tbl[13] = mk(1, 1, 1, 3, 2, 1, 16'h3456, 0, UF,       1, 1, 1); // EOF underflow + clear
        tbl[14] = mk(1, 0, 1, 0, 1, 0, 16'h8888, 1, 16'h8888, 0, 1, 1); // no extra ARM frame
        tbl[15] = mk(0, 0, 1, 1, 1, 0, 16'h9999, 0, BG,       0, 1, 1); // enable dropped
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, BG,       0, 1, 1); // IDLE -> ARM
        tbl[17] = mk(1, 0, 1, 0, 1, 0, 16'hAAAA, 0, BG,       0, 1, 1); // ARM, not streaming
        tbl[18] = mk(1, 1, 0, 0, 0, 0, 16'h0000, 0, BG,       0, 0, 0); // plain clear

        sys_rst_n        = 1'b0;
        stream_en        = 1'b0;
        clr_stats        = 1'b0;
        h_disp           = 11'd4;
        v_disp           = 11'd2;
        bus.data_req     = 1'b0;
        bus.pixel_xpos   = '0;
        bus.pixel_ypos   = '0;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        starve           = 1'b0;
        model_reset();

        #3;
        check("reset_video", bus.video_rgb_565, 16'h0000);
        check("reset_frame_start", frame_start, 1'b0);
        check("reset_cnt", underflow_cnt, 16'h0000);
        check("reset_flag", underflow_flag, 1'b0);
        check("reset_rd_en", bus.fifo_rd_en, 1'b0);
        @(posedge pixel_clk);
        #1;
        sys_rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            stream_en        = tbl[i].en;
            clr_stats        = tbl[i].clr;
            bus.data_req     = tbl[i].req;
            bus.pixel_xpos   = 11'(tbl[i].x);
            bus.pixel_ypos   = 11'(tbl[i].y);
            bus.fifo_empty   = tbl[i].empty;
            bus.fifo_rd_data = tbl[i].data;
            @(negedge pixel_clk);
            check($sformatf("vec%0d_rd_en", i), bus.fifo_rd_en, tbl[i].rd);
            @(posedge pixel_clk);
            #1;
            check($sformatf("vec%0d_video", i), bus.video_rgb_565, tbl[i].pix);
            check($sformatf("vec%0d_frame_start", i), frame_start, tbl[i].fs);
            check($sformatf("vec%0d_cnt", i), underflow_cnt, 32'(tbl[i].cnt));
            check($sformatf("vec%0d_flag", i), underflow_flag, tbl[i].flag);
        end

        // Frame-level scenarios on an 8x2 raster.
        h_disp    = 11'd8;
        v_disp    = 11'd2;
        do_reset();
        stream_en = 1'b1;
        run_frame(-1, 99, 99, 0,  0, 1);   // arming frame: BG only
        run_frame(-1, 99, 99, 1, 16, 1);   // streams ramp from 0
        run_frame(10, 99, 99, 0, 10, 1);   // underflow mid-frame
        check("uf_cnt_after_mid", underflow_cnt, 16'd1);
        check("uf_flag_after_mid", underflow_flag, 1'b1);
        run_frame(-1, 99, 99, 1, 16, 1);   // resynced at next frame
        run_frame(15, 99, 99, 0, 15, 1);   // underflow on EOF
        check("uf_cnt_after_eof", underflow_cnt, 16'd2);
        run_frame(-1, 99, 99, 1, 16, 1);   // no extra arming frame
        run_frame(-1,  5, 99, 0,  5, 0);   // enable dropped mid-line
        stream_en = 1'b1;
        run_frame(-1, 99, 99, 0,  0, 1);   // one full BG frame
        run_frame(-1, 99, 99, 1, 16, 1);

        // Asynchronous reset in the middle of a streaming frame.
        for (int idx = 0; idx < 6; idx++) begin
            bus.data_req   = 1'b1;
            bus.pixel_xpos = 11'(idx);
            bus.pixel_ypos = 11'd1;
            tick();
        end
        #2;
        sys_rst_n    = 1'b0;
        bus.data_req = 1'b0;
        model_reset();
        #1;
        check("async_rst_video", bus.video_rgb_565, 16'h0000);
        check("async_rst_frame_start", frame_start, 1'b0);
        check("async_rst_cnt", underflow_cnt, 16'h0000);
        check("async_rst_flag", underflow_flag, 1'b0);
        check("async_rst_rd_en", bus.fifo_rd_en, 1'b0);
        @(posedge pixel_clk);
        #1;
        check("async_rst_hold_video", bus.video_rgb_565, 16'h0000);
        sys_rst_n = 1'b1;
        run_frame(-1, 99, 99, 0,  0, 1);
        run_frame(-1, 99, 99, 1, 16, 1);

        // Randomized traffic on a 6x3 raster.
        h_disp = 11'd6;
        v_disp = 11'd3;
        do_reset();
        stream_en = 1'b1;
        pos = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(199) == 0) stream_en = !stream_en;
            if (!stream_en && $urandom_range(19) == 0) stream_en = 1'b1;
            clr_stats    = ($urandom_range(49) == 0);
            starve       = ($urandom_range(11) == 0);
            bus.data_req = ($urandom_range(3) != 0);
            if (bus.data_req) begin
                bus.pixel_xpos = 11'(pos % 6);
                bus.pixel_ypos = 11'(pos / 6 + 1);
                pos = (pos + 1) % 18;
            end else begin
                bus.pixel_xpos = 11'($urandom_range(7));
                bus.pixel_ypos = 11'($urandom_range(4));
            end
            tick();
        end
        clr_stats = 1'b0;

        // 1x1 raster with an empty FIFO: every request underflows; counter must saturate.
        h_disp = 11'd1;
        v_disp = 11'd1;
        do_reset();
        stream_en      = 1'b1;
        bus.data_req   = 1'b1;
        bus.pixel_xpos = 11'd0;
        bus.pixel_ypos = 11'd1;
        starve         = 1'b1;
        repeat (65540) tick();
        check("uf_cnt_saturated", underflow_cnt, 16'hFFFF);
        check("uf_flag_saturated", underflow_flag, 1'b1);
        bus.data_req = 1'b0;
        starve       = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
